token_anim_responder: RTL and testbench

UI-side responder for the game controller's position/animation handshake. It watches `pos_valid` and the player positions and steps the displayed token one cell at a time toward the new position. When the walk ends, it returns a single-cycle `turn_done` pulse. After each move it also samples the controller's `event_flag` and plays the event phase (move-back walk, banner or win hold), pulsing `turn_done` again where the controller waits for it. The board renderer reads its `disp_*` outputs.

---
 rtl/token_anim_responder_if.sv | 33 +++
 rtl/token_anim_responder.sv | 191 +++++++++++++++++++
 tb/tb_token_anim_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/token_anim_responder_if.sv
// rtl/token_anim_responder_if.sv - controller/animation handshake bundle
// Purpose: groups the game controller's position/event handshake with the
// responder's completion pulse.
// Signals:
//   pos_valid    controller -> responder  position update level
//   turn         controller -> responder  0 = player 1, 1 = player 2 moving
//   p1_pos       controller -> responder  player 1 position (0..10)
//   p2_pos       controller -> responder  player 2 position (0..10)
//   event_flag   controller -> responder  event after the move
//   winner_valid controller -> responder  a winner has been decided
//   winner_id    controller -> responder  which player won
//   turn_done    responder -> controller  single-cycle completion pulse
// Modports: master = controller side, slave = responder side.
interface token_anim_responder_if;
  logic       pos_valid;
  logic       turn;
  logic [3:0] p1_pos;
  logic [3:0] p2_pos;
  logic [3:0] event_flag;
  logic       winner_valid;
  logic       winner_id;
  logic       turn_done;

  modport master (
    output pos_valid, turn, p1_pos, p2_pos, event_flag, winner_valid, winner_id,
    input  turn_done
  );

  modport slave (
    input  pos_valid, turn, p1_pos, p2_pos, event_flag, winner_valid, winner_id,
    output turn_done
  );
endinterface

// File: rtl/token_anim_responder.sv
// rtl/token_anim_responder.sv - steps board tokens toward controller positions
// Purpose: on a pos_valid rise, walks the moving player's displayed token one
// cell per STEP_CYCLES toward its target, pulses turn_done, then plays the
// event phase (back-to-start walk, banner hold or win hold).
// Optional feature macro: TOKEN_ANIM_EVENT_BANNER_EN enables the timed banner
// state; without it banner events complete immediately and event_active is 0.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   ctrl          controller handshake (slave side, drives turn_done)
//   disp_p1/p2    displayed token cells
//   anim_player   player currently animated
//   moving        walk in progress
//   event_active  banner hold in progress
//   event_code    latched event flag, 0 when idle
//   win_show      win screen held until reset
module token_anim_responder #(
  parameter int STEP_CYCLES  = 25_000_000,
  parameter int EVENT_CYCLES = 100_000_000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  token_anim_responder_if.slave        ctrl,
  output logic [3:0]                   disp_p1,
  output logic [3:0]                   disp_p2,
  output logic                         anim_player,
  output logic                         moving,
  output logic                         event_active,
  output logic [3:0]                   event_code,
  output logic                         win_show
);

  localparam int CNT_MAX = (STEP_CYCLES > EVENT_CYCLES) ? STEP_CYCLES : EVENT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_DONE,
    S_WAIT_FALL,
    S_EVENT,
    S_WIN
  } state_t;

  state_t             state_q, state_d;
  logic               pv_q, pv_d;
  logic               anim_player_q, anim_player_d;
  logic [3:0]         target_q, target_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [3:0]         disp_p1_q, disp_p1_d;
  logic [3:0]         disp_p2_q, disp_p2_d;
  logic [3:0]         event_code_q, event_code_d;

  logic               pv_rise;
  logic [3:0]         cur_disp;
  logic [3:0]         next_disp;
  logic               unused_winner_id;

  // Winner identity is shown by the renderer from the controller directly.
  assign unused_winner_id = ctrl.winner_id;

  function automatic logic [3:0] clamp_pos(input logic [3:0] p);
    return (p > 4'd10) ? 4'd10 : p;
  endfunction

  assign pv_rise   = ctrl.pos_valid & ~pv_q;
  assign cur_disp  = anim_player_q ? disp_p2_q : disp_p1_q;
  assign next_disp = (cur_disp < target_q) ? cur_disp + 4'd1 : cur_disp - 4'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pv_q          <= 1'b0;
      anim_player_q <= 1'b0;
      target_q      <= 4'd0;
      step_cnt_q    <= '0;
      disp_p1_q     <= 4'd0;
      disp_p2_q     <= 4'd0;
      event_code_q  <= 4'd0;
    end else begin
      state_q       <= state_d;
      pv_q          <= pv_d;
      anim_player_q <= anim_player_d;
      target_q      <= target_d;
      step_cnt_q    <= step_cnt_d;
      disp_p1_q     <= disp_p1_d;
      disp_p2_q     <= disp_p2_d;
      event_code_q  <= event_code_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pv_d          = ctrl.pos_valid;
    anim_player_d = anim_player_q;
    target_d      = target_q;
    step_cnt_d    = step_cnt_q;
    disp_p1_d     = disp_p1_q;
    disp_p2_d     = disp_p2_q;
    event_code_d  = event_code_q;

    case (state_q)
      S_IDLE: begin
        event_code_d = 4'd0;
        if (pv_rise) begin
          anim_player_d = ctrl.turn;
          target_d      = clamp_pos(ctrl.turn ? ctrl.p2_pos : ctrl.p1_pos);
          step_cnt_d    = '0;
          state_d       = S_MOVE;
        end
      end

      S_MOVE: begin
        if (cur_disp == target_q) begin
          // Already on target at entry: zero-cell move.
          state_d = S_DONE;
        end else if (step_cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
          step_cnt_d = '0;
          if (anim_player_q) disp_p2_d = next_disp;
          else               disp_p1_d = next_disp;
          // Leave on the same edge as the last step so no extra step is taken.
          if (next_disp == target_q) state_d = S_DONE;
        end else begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // A nonzero code means this pulse closed an event phase.
        if (event_code_q == 4'd0) begin
          state_d = S_WAIT_FALL;
        end else begin
          state_d      = S_IDLE;
          event_code_d = 4'd0;
        end
      end

      S_WAIT_FALL: begin
        if (!ctrl.pos_valid) begin
          event_code_d = ctrl.event_flag;
          step_cnt_d   = '0;
          if (ctrl.winner_valid) begin
            event_code_d = 4'd10;
            state_d      = S_WIN;
          end else if (ctrl.event_flag == 4'd0) begin
            state_d = S_IDLE;
          end else if (ctrl.event_flag == 4'd3) begin
            target_d = clamp_pos(anim_player_q ? ctrl.p2_pos : ctrl.p1_pos);
            state_d  = S_MOVE;
          end else begin
`ifdef TOKEN_ANIM_EVENT_BANNER_EN
            state_d = S_EVENT;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

      S_EVENT: begin
        if (step_cnt_q == CNT_W'(EVENT_CYCLES - 1)) begin
          step_cnt_d = '0;
          state_d    = S_DONE;
        end else begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
      end

      S_WIN: begin
        event_code_d = 4'd10;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign disp_p1        = disp_p1_q;
  assign disp_p2        = disp_p2_q;
  assign anim_player    = anim_player_q;
  assign moving         = (state_q == S_MOVE);
  assign ctrl.turn_done = (state_q == S_DONE);
  assign event_code     = event_code_q;
  assign win_show       = (state_q == S_WIN);
`ifdef TOKEN_ANIM_EVENT_BANNER_EN
  assign event_active   = (state_q == S_EVENT);
`else
  assign event_active   = 1'b0;
`endif

endmodule

// File: tb/tb_token_anim_responder.sv
// tb/tb_token_anim_responder.sv - directed bench for token_anim_responder
module tb_token_anim_responder;

  logic       clk;
  logic       reset_n;
  logic [3:0] disp_p1;
  logic [3:0] disp_p2;
  logic       anim_player;
  logic       moving;
  logic       event_active;
  logic [3:0] event_code;
  logic       win_show;

  int n_chk;
  int n_fail;

  token_anim_responder_if bus ();

  token_anim_responder #(
    .STEP_CYCLES  (4),
    .EVENT_CYCLES (10)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl         (bus.slave),
    .disp_p1      (disp_p1),
    .disp_p2      (disp_p2),
    .anim_player  (anim_player),
    .moving       (moving),
    .event_active (event_active),
    .event_code   (event_code),
    .win_show     (win_show)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n          = 1'b0;
    bus.pos_valid    = 1'b0;
    bus.turn         = 1'b0;
    bus.p1_pos       = 4'd0;
    bus.p2_pos       = 4'd0;
    bus.event_flag   = 4'd0;
    bus.winner_valid = 1'b0;
    bus.winner_id    = 1'b0;
    cyc(2);

    // Reset state
    chk("rst_disp_p1", disp_p1, 0);
    chk("rst_disp_p2", disp_p2, 0);
    chk("rst_moving", moving, 0);
    chk("rst_turn_done", bus.turn_done, 0);
    chk("rst_event_active", event_active, 0);
    chk("rst_event_code", event_code, 0);
    chk("rst_win_show", win_show, 0);
    chk("rst_anim_player", anim_player, 0);
    reset_n = 1'b1;
    cyc(1);

    // Forward move: p1 0 -> 3, steps at k+4, k+8, k+12
    bus.turn = 1'b0; bus.p1_pos = 4'd3; bus.pos_valid = 1'b1;
    cyc(1);
    chk("fwd_moving", moving, 1);
    chk("fwd_anim_player", anim_player, 0);
    chk("fwd_disp_k", disp_p1, 0);
    cyc(3);
    chk("fwd_disp_k3", disp_p1, 0);
    cyc(1);
    chk("fwd_disp_k4", disp_p1, 1);
    cyc(4);
    chk("fwd_disp_k8", disp_p1, 2);
    cyc(3);
    chk("fwd_disp_k11", disp_p1, 2);
    chk("fwd_done_k11", bus.turn_done, 0);
    cyc(1);
    chk("fwd_disp_k12", disp_p1, 3);
    chk("fwd_done_k12", bus.turn_done, 1);
    chk("fwd_moving_end", moving, 0);
    chk("fwd_disp_p2", disp_p2, 0);
    cyc(1);
    chk("fwd_done_single", bus.turn_done, 0);

    // No-event fall: back to idle, no second pulse
    bus.pos_valid = 1'b0; bus.event_flag = 4'd0;
    cyc(1);
    chk("noev_done0", bus.turn_done, 0);
    chk("noev_code", event_code, 0);
    cyc(1);
    chk("noev_done1", bus.turn_done, 0);
    cyc(2);
    chk("noev_done3", bus.turn_done, 0);

    // Back-to-start: p2 walks to 3, then flag 3 walks it back to 0
    bus.turn = 1'b1; bus.p2_pos = 4'd3; bus.pos_valid = 1'b1;
    cyc(1);
    chk("b2s_anim_player", anim_player, 1);
    chk("b2s_moving", moving, 1);
    cyc(12);
    chk("b2s_disp_fwd", disp_p2, 3);
    chk("b2s_done1", bus.turn_done, 1);
    cyc(1);
    chk("b2s_done1_off", bus.turn_done, 0);
    bus.pos_valid = 1'b0; bus.event_flag = 4'd3; bus.p2_pos = 4'd0;
    cyc(1);
    chk("b2s_code_f", event_code, 3);
    chk("b2s_moving_f", moving, 1);
    chk("b2s_disp_f", disp_p2, 3);
    cyc(4);
    chk("b2s_disp_f4", disp_p2, 2);
    chk("b2s_code_f4", event_code, 3);
    cyc(4);
    chk("b2s_disp_f8", disp_p2, 1);
    cyc(3);
    chk("b2s_done_f11", bus.turn_done, 0);
    cyc(1);
    chk("b2s_disp_f12", disp_p2, 0);
    chk("b2s_done2", bus.turn_done, 1);
    chk("b2s_code_f12", event_code, 3);
    cyc(1);
    chk("b2s_done2_off", bus.turn_done, 0);
    chk("b2s_code_idle", event_code, 0);
    chk("b2s_disp_p1", disp_p1, 3);
    bus.event_flag = 4'd0;

    // Zero move: p1 already at 3
    bus.turn = 1'b0; bus.p1_pos = 4'd3; bus.pos_valid = 1'b1;
    cyc(1);
    chk("zero_moving", moving, 1);
    chk("zero_done_k", bus.turn_done, 0);
    cyc(1);
    chk("zero_done_k1", bus.turn_done, 1);
    chk("zero_disp", disp_p1, 3);
    cyc(1);
    chk("zero_done_off", bus.turn_done, 0);

    // Banner event flag 6
    bus.pos_valid = 1'b0; bus.event_flag = 4'd6;
    cyc(1);
    chk("ban_code", event_code, 6);
`ifdef TOKEN_ANIM_EVENT_BANNER_EN
    chk("ban_active_s", event_active, 1);
    chk("ban_done_s", bus.turn_done, 0);
    cyc(9);
    chk("ban_active_s9", event_active, 1);
    chk("ban_done_s9", bus.turn_done, 0);
    cyc(1);
    chk("ban_active_s10", event_active, 0);
    chk("ban_done_s10", bus.turn_done, 1);
`else
    chk("ban_active_off", event_active, 0);
    chk("ban_done_s", bus.turn_done, 1);
`endif
    cyc(1);
    chk("ban_done_off", bus.turn_done, 0);
    chk("ban_code_clear", event_code, 0);
    bus.event_flag = 4'd0;

    // Mid-walk reset
    bus.turn = 1'b1; bus.p2_pos = 4'd2; bus.pos_valid = 1'b1;
    cyc(5);
    chk("mrst_pre_disp", disp_p2, 1);
    chk("mrst_pre_moving", moving, 1);
    reset_n = 1'b0; bus.pos_valid = 1'b0;
    cyc(1);
    chk("mrst_disp_p1", disp_p1, 0);
    chk("mrst_disp_p2", disp_p2, 0);
    chk("mrst_moving", moving, 0);
    chk("mrst_anim_player", anim_player, 0);
    chk("mrst_done", bus.turn_done, 0);
    reset_n = 1'b1;
    cyc(1);
    bus.turn = 1'b0; bus.p1_pos = 4'd1; bus.pos_valid = 1'b1;
    cyc(1);
    chk("mrst_accept", moving, 1);
    cyc(4);
    chk("mrst_disp_after", disp_p1, 1);
    chk("mrst_done_after", bus.turn_done, 1);
    cyc(1);
    bus.pos_valid = 1'b0;
    cyc(2);

    // Clamp and win: p1 to 9, then target 13 clamps to 10
    bus.p1_pos = 4'd9; bus.pos_valid = 1'b1;
    cyc(33);
    chk("clamp_pre_disp", disp_p1, 9);
    chk("clamp_pre_done", bus.turn_done, 1);
    cyc(1);
    bus.pos_valid = 1'b0;
    cyc(2);
    bus.p1_pos = 4'd13; bus.pos_valid = 1'b1;
    cyc(5);
    chk("clamp_disp", disp_p1, 10);
    chk("clamp_done", bus.turn_done, 1);
    cyc(1);
    chk("clamp_no_extra", disp_p1, 10);
    bus.pos_valid = 1'b0; bus.winner_valid = 1'b1; bus.event_flag = 4'd10;
    cyc(1);
    chk("win_show", win_show, 1);
    chk("win_code", event_code, 10);
    chk("win_done", bus.turn_done, 0);
    cyc(5);
    chk("win_held", win_show, 1);
    bus.turn = 1'b1; bus.p2_pos = 4'd5; bus.pos_valid = 1'b1;
    cyc(3);
    chk("win_ignore_moving", moving, 0);
    chk("win_ignore_disp", disp_p2, 0);
    chk("win_still", win_show, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
